// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD command-line engine.
// Response-type codes, CRC7 polynomial and token widths live here.
package sd_pkg;

  localparam logic [1:0] RESP_NONE  = 2'b00;
  localparam logic [1:0] RESP_SHORT = 2'b01;
  localparam logic [1:0] RESP_LONG  = 2'b10;

  // x^7 + x^3 + 1 with the x^7 term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int CMD_TOKEN_W  = 48;
  localparam int RESP_SHORT_W = 48;
  localparam int RESP_LONG_W  = 136;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    TX,
    NCR_WAIT,
    RX,
    GAP,
    FIN
  } sd_state_t;

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 accumulator; one bit per enabled cycle, MSB first.
// clr wins over en so a new frame can start from a clean register.
module sd_crc7_serial
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;

  assign fb = crc[6] ^ din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sends a 48-bit command token with CRC7 and optionally
// captures a 48/136-bit response, all paced by an internal SD bit tick.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NCR_MAX = 64,
  parameter int NRC_GAP = 8
) (
  input  logic         ex_clk,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         check_crc,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  output logic         sd_clk_tick,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic         crc_err,
  output logic [135:0] resp
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  sd_state_t     state, state_d;
  logic [DW-1:0] div_cnt;
  logic [15:0]   cnt, cnt_d;
  logic [39:0]   shift_q, shift_d;
  logic [1:0]    kind_q, kind_d;
  logic          chk_q, chk_d;
  logic          cmd_o_d, cmd_oe_d, timeout_d, crc_err_d;
  logic [135:0]  resp_d;
  logic          crc_clr, crc_en, crc_din;
  logic [6:0]    crc;
  logic          rx_last;

  // Free-running divider; it never stops so start latency depends on phase.
  always_ff @(posedge ex_clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DW'(CLK_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign sd_clk_tick = (div_cnt == DW'(CLK_DIV - 1));
  assign busy        = (state != IDLE) && (state != FIN);
  assign done        = (state == FIN);

  // Counter counts total bits including the start bit consumed in NCR_WAIT.
  assign rx_last = (kind_q == RESP_LONG) ? (cnt == 16'(RESP_LONG_W - 1))
                                         : (cnt == 16'(RESP_SHORT_W - 1));

  sd_crc7_serial u_crc (
    .clk   (ex_clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc)
  );

  always_ff @(posedge ex_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_q   <= '0;
      kind_q    <= RESP_NONE;
      chk_q     <= 1'b0;
      sd_cmd_o  <= 1'b1;
      sd_cmd_oe <= 1'b0;
      timeout   <= 1'b0;
      crc_err   <= 1'b0;
      resp      <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      shift_q   <= shift_d;
      kind_q    <= kind_d;
      chk_q     <= chk_d;
      sd_cmd_o  <= cmd_o_d;
      sd_cmd_oe <= cmd_oe_d;
      timeout   <= timeout_d;
      crc_err   <= crc_err_d;
      resp      <= resp_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    shift_d   = shift_q;
    kind_d    = kind_q;
    chk_d     = chk_q;
    cmd_o_d   = sd_cmd_o;
    cmd_oe_d  = sd_cmd_oe;
    timeout_d = timeout;
    crc_err_d = crc_err;
    resp_d    = resp;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_din   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shift_d   = {1'b0, 1'b1, cmd_index, cmd_arg};
          kind_d    = (resp_type == RESP_SHORT || resp_type == RESP_LONG) ? resp_type : RESP_NONE;
          chk_d     = check_crc;
          timeout_d = 1'b0;
          crc_err_d = 1'b0;
          resp_d    = '0;
          crc_clr   = 1'b1;
          cnt_d     = '0;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (sd_clk_tick) begin
          cmd_oe_d = 1'b1;
          cmd_o_d  = shift_q[39];
          crc_en   = 1'b1;
          crc_din  = shift_q[39];
          shift_d  = {shift_q[38:0], 1'b0};
          cnt_d    = 16'd1;
          state_d  = TX;
        end
      end
      TX: begin
        if (sd_clk_tick) begin
          if (cnt < 16'd40) begin
            cmd_o_d = shift_q[39];
            crc_en  = 1'b1;
            crc_din = shift_q[39];
            shift_d = {shift_q[38:0], 1'b0};
            cnt_d   = cnt + 16'd1;
          end else if (cnt < 16'd47) begin
            // token bit 7 is crc[6] down to token bit 1 as crc[0]
            cmd_o_d = crc[3'(7'd46 - cnt[6:0])];
            cnt_d   = cnt + 16'd1;
          end else if (cnt == 16'd47) begin
            cmd_o_d = 1'b1;
            cnt_d   = cnt + 16'd1;
          end else begin
            cnt_d = '0;
            if (kind_q == RESP_NONE) begin
              state_d = GAP;
            end else begin
              cmd_oe_d = 1'b0;
              crc_clr  = 1'b1;
              state_d  = NCR_WAIT;
            end
          end
        end
      end
      NCR_WAIT: begin
        if (sd_clk_tick) begin
          if (!sd_cmd_i) begin
            resp_d  = {resp[134:0], 1'b0};
            crc_en  = 1'b1;
            crc_din = 1'b0;
            cnt_d   = 16'd1;
            state_d = RX;
          end else if (cnt == 16'(NCR_MAX - 1)) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = GAP;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end
      RX: begin
        if (sd_clk_tick) begin
          resp_d = {resp[134:0], sd_cmd_i};
          if (kind_q == RESP_SHORT && cnt < 16'd40) begin
            crc_en  = 1'b1;
            crc_din = sd_cmd_i;
          end
          if (rx_last) begin
            // resp[6:0] still holds received bits 7..1 before this shift
            if (kind_q == RESP_SHORT && chk_q && crc != resp[6:0]) begin
              crc_err_d = 1'b1;
            end
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end
      GAP: begin
        if (sd_clk_tick) begin
          if (cnt == 16'(NRC_GAP - 1)) begin
            cmd_oe_d = 1'b0;
            cmd_o_d  = 1'b1;
            cnt_d    = '0;
            state_d  = FIN;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: a card model on the CMD line and a
// reference that derives tokens, CRCs and timing from the command rules.
module tb_sd_cmd_engine;

  localparam int CLK_DIV = 4;
  localparam int NCR_MAX = 64;
  localparam int NRC_GAP = 8;

  logic         ex_clk;
  logic         reset;
  logic         start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         check_crc;
  logic         sd_cmd_i;
  logic         sd_cmd_o;
  logic         sd_cmd_oe;
  logic         sd_clk_tick;
  logic         busy;
  logic         done;
  logic         timeout;
  logic         crc_err;
  logic [135:0] resp;

  int n_tests = 0;
  int n_fail  = 0;

  // observations collected by do_txn
  logic [47:0]  obs_tx;
  logic [135:0] obs_resp;
  int           obs_lat, obs_oe_bad, obs_ticks, obs_idle_bad;
  bit           obs_done_seen, obs_busy_start, obs_busy_done, obs_done_next;
  bit           obs_to, obs_ce, obs_to_start;

  sd_cmd_engine #(
    .CLK_DIV (CLK_DIV),
    .NCR_MAX (NCR_MAX),
    .NRC_GAP (NRC_GAP)
  ) dut (
    .ex_clk      (ex_clk),
    .reset       (reset),
    .start       (start),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .resp_type   (resp_type),
    .check_crc   (check_crc),
    .sd_cmd_i    (sd_cmd_i),
    .sd_cmd_o    (sd_cmd_o),
    .sd_cmd_oe   (sd_cmd_oe),
    .sd_clk_tick (sd_clk_tick),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .crc_err     (crc_err),
    .resp        (resp)
  );

  initial ex_clk = 1'b0;
  always #5 ex_clk = ~ex_clk;

  // CRC7 as the remainder of polynomial long division by x^7+x^3+1
  function automatic logic [6:0] model_crc7(input logic [39:0] d);
    logic [46:0] m;
    logic [46:0] g;
    m = {d, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      g = 47'h89;
      if (m[i]) m = m ^ (g << (i - 7));
    end
    return m[6:0];
  endfunction

  function automatic logic [47:0] model_token(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] p;
    p = {2'b01, idx, arg};
    return {p, model_crc7(p), 1'b1};
  endfunction

  function automatic int model_ticks(input logic [1:0] rt, input bit answer, input int delay);
    if (rt != 2'b01 && rt != 2'b10) return 1 + NRC_GAP;
    if (!answer || delay >= NCR_MAX) return NCR_MAX + NRC_GAP;
    return delay + ((rt == 2'b10) ? 136 : 48) + NRC_GAP;
  endfunction

  task automatic do_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                        input logic chk, input bit answer, input int delay,
                        input logic [135:0] rbits, input int rlen, input bit poke,
                        input bit start_at_done);
    int  n, guard;
    bit  resp_exp;
    resp_exp = (rt == 2'b01 || rt == 2'b10);
    repeat ($urandom_range(0, CLK_DIV - 1)) @(negedge ex_clk);
    cmd_index = idx; cmd_arg = arg; resp_type = rt; check_crc = chk; start = 1'b1;
    @(negedge ex_clk);
    start = 1'b0;
    obs_busy_start = busy;
    obs_to_start   = timeout;
    obs_lat = 1;
    while (!sd_cmd_oe && obs_lat < 4 * CLK_DIV) begin
      @(negedge ex_clk);
      obs_lat++;
    end
    obs_oe_bad = 0;
    obs_tx[47] = sd_cmd_o;
    for (int j = 46; j >= 0; j--) begin
      repeat (CLK_DIV) @(negedge ex_clk);
      obs_tx[j] = sd_cmd_o;
      if (!sd_cmd_oe) obs_oe_bad++;
    end
    if (resp_exp) begin
      guard = 0;
      while (sd_cmd_oe && guard < 2 * CLK_DIV) begin
        @(negedge ex_clk);
        guard++;
      end
      if (sd_cmd_oe) obs_oe_bad++;
    end
    n = 0; guard = 0; obs_done_seen = 0;
    while (guard < 20000) begin
      @(negedge ex_clk);
      guard++;
      start = 1'b0;
      if (done) begin
        obs_done_seen = 1;
        break;
      end
      if (sd_cmd_oe !== !resp_exp) obs_oe_bad++;
      if (sd_clk_tick) begin
        n++;
        if (resp_exp) begin
          if (answer && n > delay && (n - delay - 1) < rlen) sd_cmd_i = rbits[rlen - 1 - (n - delay - 1)];
          else sd_cmd_i = 1'b1;
          if (poke && n == delay + 10) begin
            start = 1'b1; cmd_index = 6'($urandom); cmd_arg = $urandom; resp_type = 2'($urandom);
          end
        end
      end
    end
    obs_ticks = n; obs_busy_done = busy; obs_to = timeout; obs_ce = crc_err; obs_resp = resp;
    sd_cmd_i = 1'b1;
    if (start_at_done) start = 1'b1;
    @(negedge ex_clk);
    start = 1'b0;
    obs_done_next = done;
    obs_idle_bad = 0;
    repeat (3 * CLK_DIV) begin
      @(negedge ex_clk);
      if (busy || sd_cmd_oe || done) obs_idle_bad++;
    end
  endtask

  task automatic test_reset;
    int k;
    reset = 1'b1; start = 1'b0; sd_cmd_i = 1'b1;
    cmd_index = '0; cmd_arg = '0; resp_type = '0; check_crc = 1'b0;
    repeat (3) @(negedge ex_clk);
    n_tests++;
    if ({sd_cmd_o, sd_cmd_oe, busy, done, timeout, crc_err, sd_clk_tick} !== 7'b1000000 || resp !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got o/oe/busy/done/to/ce/tick=%b resp=%h, want 1000000 and 0",
               {sd_cmd_o, sd_cmd_oe, busy, done, timeout, crc_err, sd_clk_tick}, resp);
    end
    reset = 1'b0;
    k = 0;
    while (k < 4 * CLK_DIV) begin
      @(negedge ex_clk);
      k++;
      if (sd_clk_tick) break;
    end
    n_tests++;
    if (k !== CLK_DIV - 1) begin
      n_fail++;
      $display("FAIL first_tick: got tick after %0d cycles, want %0d", k, CLK_DIV - 1);
    end
    k = 0;
    repeat (10 * CLK_DIV) begin
      @(negedge ex_clk);
      if (sd_clk_tick) k++;
    end
    n_tests++;
    if (k !== 10) begin
      n_fail++;
      $display("FAIL tick_rate: got %0d ticks, want 10", k);
    end
  endtask

  task automatic test_cmd0;
    do_txn(6'd0, 32'd0, 2'b00, 1'b0, 0, 0, '0, 0, 0, 0);
    n_tests++;
    if (obs_tx !== 48'h40_0000_0000_95) begin
      n_fail++; $display("FAIL cmd0_token: got %h, want 400000000095", obs_tx);
    end
    n_tests++;
    if (obs_lat < 2 || obs_lat > CLK_DIV + 1) begin
      n_fail++; $display("FAIL cmd0_latency: got %0d cycles, want 1..%0d", obs_lat - 1, CLK_DIV);
    end
    n_tests++;
    if (!obs_done_seen || obs_ticks !== 1 + NRC_GAP) begin
      n_fail++; $display("FAIL cmd0_done_time: seen=%0d ticks=%0d, want 1 and %0d", obs_done_seen, obs_ticks, 1 + NRC_GAP);
    end
    n_tests++;
    if (obs_oe_bad !== 0 || obs_busy_start !== 1'b1 || obs_busy_done !== 1'b0 || obs_done_next !== 1'b0) begin
      n_fail++; $display("FAIL cmd0_ctrl: oe_bad=%0d busy_start=%0d busy_done=%0d done_next=%0d, want 0 1 0 0",
                         obs_oe_bad, obs_busy_start, obs_busy_done, obs_done_next);
    end
    n_tests++;
    if (obs_to !== 1'b0 || obs_ce !== 1'b0 || obs_resp !== '0 || obs_idle_bad !== 0) begin
      n_fail++; $display("FAIL cmd0_flags: to=%0d ce=%0d resp=%h idle_bad=%0d, want 0 0 0 0", obs_to, obs_ce, obs_resp, obs_idle_bad);
    end
  endtask

  task automatic test_cmd8_short;
    logic [135:0] r;
    r = {88'b0, 48'h08_0000_01AA_13};
    do_txn(6'd8, 32'h1AA, 2'b01, 1'b1, 1, 5, r, 48, 0, 0);
    n_tests++;
    if (obs_tx !== 48'h48_0000_01AA_87) begin
      n_fail++; $display("FAIL cmd8_token: got %h, want 48000001AA87", obs_tx);
    end
    n_tests++;
    if (obs_resp !== r || obs_ce !== 1'b0 || obs_to !== 1'b0) begin
      n_fail++; $display("FAIL cmd8_resp: got resp=%h ce=%0d to=%0d, want %h 0 0", obs_resp, obs_ce, obs_to, r);
    end
    n_tests++;
    if (!obs_done_seen || obs_ticks !== model_ticks(2'b01, 1, 5) || obs_oe_bad !== 0) begin
      n_fail++; $display("FAIL cmd8_timing: seen=%0d ticks=%0d oe_bad=%0d, want 1 %0d 0",
                         obs_done_seen, obs_ticks, obs_oe_bad, model_ticks(2'b01, 1, 5));
    end
  endtask

  task automatic test_crc_flip;
    logic [135:0] r;
    r = {88'b0, 48'h08_0000_01AA_13 ^ 48'h8};
    do_txn(6'd8, 32'h1AA, 2'b01, 1'b1, 1, 5, r, 48, 0, 0);
    n_tests++;
    if (obs_ce !== 1'b1 || !obs_done_seen || obs_resp !== r) begin
      n_fail++; $display("FAIL crc_flip: ce=%0d done=%0d resp=%h, want 1 1 %h", obs_ce, obs_done_seen, obs_resp, r);
    end
    do_txn(6'd41, 32'h40FF_8000, 2'b01, 1'b0, 1, 3, r, 48, 0, 0);
    n_tests++;
    if (obs_ce !== 1'b0 || obs_resp !== r || obs_to_start !== 1'b0) begin
      n_fail++; $display("FAIL crc_unchecked: ce=%0d resp=%h, want 0 %h", obs_ce, obs_resp, r);
    end
  endtask

  task automatic test_timeout;
    do_txn(6'd17, 32'd0, 2'b01, 1'b1, 0, 0, '0, 48, 0, 0);
    n_tests++;
    if (obs_tx !== 48'h51_0000_0000_55) begin
      n_fail++; $display("FAIL cmd17_token: got %h, want 510000000055", obs_tx);
    end
    n_tests++;
    if (obs_to !== 1'b1 || obs_resp !== '0 || obs_ce !== 1'b0 || obs_ticks !== NCR_MAX + NRC_GAP) begin
      n_fail++; $display("FAIL timeout: to=%0d resp=%h ce=%0d ticks=%0d, want 1 0 0 %0d",
                         obs_to, obs_resp, obs_ce, obs_ticks, NCR_MAX + NRC_GAP);
    end
    n_tests++;
    if (timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_hold: got %0d after idle, want 1", timeout);
    end
  endtask

  task automatic test_ncr_boundary;
    logic [135:0] r;
    logic [39:0]  p;
    p = {2'b00, 6'd13, 32'h0000_0900};
    r = {88'b0, p, model_crc7(p), 1'b1};
    do_txn(6'd13, 32'h1234_0000, 2'b01, 1'b1, 1, NCR_MAX - 1, r, 48, 0, 0);
    n_tests++;
    if (obs_to_start !== 1'b0 || obs_to !== 1'b0 || obs_resp !== r || obs_ce !== 1'b0) begin
      n_fail++; $display("FAIL ncr_last_tick: to=%0d resp=%h ce=%0d, want 0 %h 0", obs_to, obs_resp, obs_ce, r);
    end
    do_txn(6'd13, 32'h1234_0000, 2'b01, 1'b1, 1, NCR_MAX, r, 48, 0, 0);
    n_tests++;
    if (obs_to !== 1'b1 || obs_resp !== '0 || obs_ticks !== NCR_MAX + NRC_GAP) begin
      n_fail++; $display("FAIL ncr_past_limit: to=%0d resp=%h ticks=%0d, want 1 0 %0d", obs_to, obs_resp, obs_ticks, NCR_MAX + NRC_GAP);
    end
  endtask

  task automatic test_long;
    logic [135:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    r[135:134] = 2'b00;
    r[0] = 1'b1;
    do_txn(6'd2, 32'd0, 2'b10, 1'b1, 1, 7, r, 136, 1, 0);
    n_tests++;
    if (obs_resp !== r || obs_ce !== 1'b0 || obs_to !== 1'b0) begin
      n_fail++; $display("FAIL long_resp: got %h ce=%0d to=%0d, want %h 0 0", obs_resp, obs_ce, obs_to, r);
    end
    n_tests++;
    if (obs_tx !== model_token(6'd2, 32'd0) || obs_ticks !== model_ticks(2'b10, 1, 7) || obs_idle_bad !== 0) begin
      n_fail++; $display("FAIL long_txn: tx=%h ticks=%0d idle_bad=%0d, want %h %0d 0",
                         obs_tx, obs_ticks, obs_idle_bad, model_token(6'd2, 32'd0), model_ticks(2'b10, 1, 7));
    end
  endtask

  task automatic test_back_to_back;
    do_txn(6'd55, 32'hDEAD_BEEF, 2'b11, 1'b0, 0, 0, '0, 0, 0, 1);
    n_tests++;
    if (obs_idle_bad !== 0 || obs_ticks !== 1 + NRC_GAP || obs_oe_bad !== 0) begin
      n_fail++; $display("FAIL start_on_done: idle_bad=%0d ticks=%0d oe_bad=%0d, want 0 %0d 0", obs_idle_bad, obs_ticks, obs_oe_bad, 1 + NRC_GAP);
    end
    n_tests++;
    if (obs_tx !== model_token(6'd55, 32'hDEAD_BEEF)) begin
      n_fail++; $display("FAIL resp_type3_token: got %h, want %h", obs_tx, model_token(6'd55, 32'hDEAD_BEEF));
    end
  endtask

  task automatic test_reset_mid_tx;
    int guard, dones;
    cmd_index = 6'd17; cmd_arg = 32'h0; resp_type = 2'b01; check_crc = 1'b1; start = 1'b1;
    @(negedge ex_clk);
    start = 1'b0;
    guard = 0;
    while (!sd_cmd_oe && guard < 4 * CLK_DIV) begin
      @(negedge ex_clk);
      guard++;
    end
    repeat (20 * CLK_DIV) @(negedge ex_clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (sd_cmd_oe !== 1'b0 || busy !== 1'b0 || sd_cmd_o !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: oe=%0d busy=%0d o=%0d done=%0d, want 0 0 1 0", sd_cmd_oe, busy, sd_cmd_o, done);
    end
    @(negedge ex_clk);
    reset = 1'b0;
    dones = 0;
    repeat (150 * CLK_DIV) begin
      @(negedge ex_clk);
      if (done || busy || sd_cmd_oe) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL mid_reset_quiet: got %0d active cycles, want 0", dones);
    end
    do_txn(6'd0, 32'd0, 2'b00, 1'b0, 0, 0, '0, 0, 0, 0);
    n_tests++;
    if (obs_tx !== 48'h40_0000_0000_95 || !obs_done_seen) begin
      n_fail++; $display("FAIL post_reset_cmd0: tx=%h done=%0d, want 400000000095 1", obs_tx, obs_done_seen);
    end
  endtask

  task automatic test_random;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rt;
    logic         chk;
    int           delay, rlen;
    logic [135:0] r, exp_resp;
    logic [39:0]  p;
    bit           resp_exp, to_exp, ce_exp;
    for (int it = 0; it < 8; it++) begin
      idx = 6'($urandom); arg = $urandom; rt = 2'($urandom); chk = 1'($urandom);
      delay = $urandom_range(0, NCR_MAX + 2);
      resp_exp = (rt == 2'b01 || rt == 2'b10);
      if (rt == 2'b10) begin
        rlen = 136;
        r = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
        r[135:134] = 2'b00; r[0] = 1'b1;
      end else begin
        rlen = 48;
        p = {2'b00, 6'($urandom), 32'($urandom)};
        r = {88'b0, p, model_crc7(p), 1'b1};
        if ($urandom_range(0, 1) == 1) r[$urandom_range(1, 46)] ^= 1'b1;
      end
      to_exp   = resp_exp && delay >= NCR_MAX;
      exp_resp = (!resp_exp || to_exp) ? '0 : r;
      ce_exp   = (rt == 2'b01) && !to_exp && chk && (model_crc7(r[47:8]) != r[7:1]);
      do_txn(idx, arg, rt, chk, 1, delay, r, rlen, 0, 0);
      n_tests++;
      if (obs_tx !== model_token(idx, arg) || obs_resp !== exp_resp || obs_to !== to_exp || obs_ce !== ce_exp
          || obs_ticks !== model_ticks(rt, 1, delay) || !obs_done_seen || obs_oe_bad !== 0) begin
        n_fail++;
        $display("FAIL random_%0d: rt=%0d d=%0d tx=%h resp=%h to=%0d ce=%0d ticks=%0d oe_bad=%0d, want %h %h %0d %0d %0d 0",
                 it, rt, delay, obs_tx, obs_resp, obs_to, obs_ce, obs_ticks, obs_oe_bad,
                 model_token(idx, arg), exp_resp, to_exp, ce_exp, model_ticks(rt, 1, delay));
      end
    end
  endtask

  initial begin
    test_reset;
    test_cmd0;
    test_cmd8_short;
    test_crc_flip;
    test_timeout;
    test_ncr_boundary;
    test_long;
    test_back_to_back;
    test_reset_mid_tx;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
